data_access_unit: RTL

- Pipeline-side master for the data bus; sits between the memory stage of the pipelined processor and the bus decoder (avalon_bus).
- Accepts one load/store request at a time via valid/ready.
- Drives the bus read/write strobe, address and write data, and holds them stable until the bus reports done.
- Returns load data and the destination register to writeback, then inserts one idle cycle so device done-flops clear before the next access.

---
 rtl/data_access_pkg.sv | 19 +
 rtl/data_access_unit_bus_timeout_ctr.sv | 37 +++
 rtl/data_access_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/data_access_pkg.sv
// Shared definitions for the pipeline data-bus master and the bus decoder.
package data_access_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_e;

  // Load data returned when an access is abandoned by the bus timeout.
  localparam logic [15:0] ERR_DATA = 16'hDEAD;

  // Device-select nibble (address bits [15:12]), decoded by avalon_bus.
  localparam logic [3:0] DEV_MEM    = 4'h0;
  localparam logic [3:0] DEV_ONCHIP = 4'h1;
  localparam logic [3:0] DEV_IO     = 4'h2;

endpackage

// File: rtl/data_access_unit_bus_timeout_ctr.sv
// Access watchdog for data_access_unit; only built with BUS_TIMEOUT_EN.
// expired is registered and is high during the LIMIT-th enabled cycle
// after clear, so the FSM can abort on the edge ending that cycle.
`ifdef BUS_TIMEOUT_EN
module bus_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 255) ? $clog2(LIMIT + 1) : 8;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc_c;

  assign count_inc_c = count_q + CNT_W'(1);

  // Count stalled ACCESS cycles; LIMIT = 0 never expires.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      expired <= (LIMIT == 1);
    end else if (enable) begin
      count_q <= count_inc_c;
      expired <= (LIMIT != 0) && (count_inc_c == CNT_W'(LIMIT - 1));
    end
  end

endmodule
`endif

// File: rtl/data_access_unit.sv
// Pipeline-side data bus master: one load/store at a time, strobes held
// until bus_done, one-cycle response pulse, then a mandatory idle cycle.
// Optional BUS_TIMEOUT_EN adds an access watchdog (resp_err, ERR_DATA).
module data_access_unit
  import data_access_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned RD_W           = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              resp_valid,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_data,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_err,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_done
);

  localparam logic [1:0] ST_IDLE    = 2'(S_IDLE);
  localparam logic [1:0] ST_ACCESS  = 2'(S_ACCESS);
  localparam logic [1:0] ST_RECOVER = 2'(S_RECOVER);

  logic [1:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              req_ready_d;
  logic              bus_read_d, bus_write_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic              resp_valid_d, resp_write_d, resp_err_d;
  logic [DATA_W-1:0] resp_data_d;
  logic [RD_W-1:0]   resp_rd_d;
  logic              timeout_c;

`ifdef BUS_TIMEOUT_EN
  logic tmo_clear_c;
  logic tmo_enable_c;

  // Watchdog restarts on acceptance and advances on every stalled ACCESS cycle.
  assign tmo_clear_c  = (state_q == ST_IDLE) && req_valid;
  assign tmo_enable_c = (state_q == ST_ACCESS) && !bus_done;

  bus_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (tmo_clear_c),
    .enable  (tmo_enable_c),
    .expired (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    req_ready_d  = req_ready;
    bus_read_d   = bus_read;
    bus_write_d  = bus_write;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    resp_valid_d = 1'b0;
    resp_write_d = resp_write;
    resp_data_d  = resp_data;
    resp_rd_d    = resp_rd;
    resp_err_d   = resp_err;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_ACCESS;
          wr_d        = req_write;
          rd_d        = req_rd;
          bus_addr_d  = req_addr;
          bus_wdata_d = req_wdata;
          bus_read_d  = !req_write;
          bus_write_d = req_write;
          req_ready_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        // bus_done wins over a simultaneous timeout.
        if (bus_done || timeout_c) begin
          state_d      = ST_RECOVER;
          bus_read_d   = 1'b0;
          bus_write_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_write_d = wr_q;
          resp_rd_d    = rd_q;
          resp_err_d   = !bus_done;
          if (!bus_done)
            resp_data_d = DATA_W'(ERR_DATA);
          else if (wr_q)
            resp_data_d = '0;
          else
            resp_data_d = bus_rdata;
        end
      end
      ST_RECOVER: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        bus_read_d  = 1'b0;
        bus_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the strobes immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      rd_q       <= '0;
      req_ready  <= 1'b1;
      bus_read   <= 1'b0;
      bus_write  <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      req_ready  <= req_ready_d;
      bus_read   <= bus_read_d;
      bus_write  <= bus_write_d;
      bus_addr   <= bus_addr_d;
      bus_wdata  <= bus_wdata_d;
      resp_valid <= resp_valid_d;
      resp_write <= resp_write_d;
      resp_data  <= resp_data_d;
      resp_rd    <= resp_rd_d;
      resp_err   <= resp_err_d;
    end
  end

endmodule
